// File: rtl/sha3_pkg.sv
// Shared SHA3 arbitration types: block/digest sizes, arbiter state encoding
// and the round-robin pick helper.
package sha3_pkg;

    localparam int SHA3_RATE_BITS   = 1088;
    localparam int SHA3_DIGEST_BITS = 256;
    localparam int RR_MAX           = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        NEXT  = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

    // Scan from ptr+n down to ptr+1 so the candidate closest to ptr+1 is written last and wins.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int                n);
        logic [2:0] pick;
        logic [2:0] idx;
        pick = ptr;
        for (int k = n; k >= 1; k--) begin
            idx = 3'((int'(ptr) + k) % n);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sha3_core_arbiter_rr_arbiter.sv
// Combinational NUM_REQ-wide round-robin pick; search starts one past ptr.
module rr_arbiter
    import sha3_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               gnt_any,
    output logic [IW-1:0]      gnt_idx,
    output logic [NUM_REQ-1:0] gnt_oh
);

    logic [RR_MAX-1:0] req_ext;
    logic [2:0]        pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick                   = rr_pick(req_ext, 3'(ptr), NUM_REQ);
        gnt_idx                = IW'(pick);
        gnt_any                = |req;
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_oh
        assign gnt_oh[i] = gnt_any && (gnt_idx == IW'(i));
    end

endmodule

// File: rtl/sha3_core_arbiter.sv
// Shares one SHA3 core among NUM_REQ requesters with per-message locked
// round-robin grants, digest forwarding, protocol-error flag and watchdog abort.
module sha3_core_arbiter
    import sha3_pkg::*;
#(
    parameter  int NUM_REQ     = 2,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int IW          = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*SHA3_RATE_BITS-1:0]  req_block,
    input  logic [NUM_REQ-1:0]                 req_more,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [SHA3_DIGEST_BITS-1:0]        rsp_hash,
    output logic                               rsp_err,
    output logic [SHA3_RATE_BITS-1:0]          core_in,
    output logic                               core_more,
    output logic                               core_in_valid,
    output logic                               core_abort,
    input  logic [SHA3_DIGEST_BITS-1:0]        core_out,
    input  logic                               core_hash_next,
    input  logic                               core_out_valid,
    output logic                               busy,
    output logic [IW-1:0]                      grant_id,
    output logic                               proto_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);

    arb_state_e                                 state;
    logic [IW-1:0]                              rr_ptr;
    logic                                       more_lat;
    logic [WD_W-1:0]                            wd_cnt;

    logic [NUM_REQ-1:0][SHA3_RATE_BITS-1:0]     blk;
    logic                                       gnt_any;
    logic [IW-1:0]                              gnt_idx;
    logic [NUM_REQ-1:0]                         gnt_oh;
    logic [NUM_REQ-1:0]                         own_oh;
    logic [IW-1:0]                              issue_idx;
    logic                                       issue;
    logic                                       wd_hit;

    assign blk    = req_block;
    assign busy   = (state != IDLE);
    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx),
        .gnt_oh  (gnt_oh)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_own
        assign own_oh[i] = (grant_id == IW'(i));
    end

    // In NEXT only the current owner may continue; an expiring watchdog blocks the accept.
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            if (state == IDLE)               req_ready = gnt_oh;
            else if (state == NEXT && !wd_hit) req_ready = own_oh & req_valid;
        end
        issue     = |req_ready;
        issue_idx = (state == IDLE) ? gnt_idx : grant_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= IW'(NUM_REQ - 1);
            more_lat      <= 1'b0;
            wd_cnt        <= '0;
            grant_id      <= '0;
            core_in       <= '0;
            core_more     <= 1'b0;
            core_in_valid <= 1'b0;
            core_abort    <= 1'b0;
            rsp_valid     <= '0;
            rsp_hash      <= '0;
            rsp_err       <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            core_in_valid <= issue;
            core_abort    <= 1'b0;
            rsp_valid     <= '0;
            rsp_err       <= 1'b0;

            if (issue) begin
                core_in   <= blk[issue_idx];
                core_more <= req_more[issue_idx];
                more_lat  <= req_more[issue_idx];
                grant_id  <= issue_idx;
            end

            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (issue) state <= BUSY;
                end
                BUSY: begin
                    if (core_out_valid) begin
                        rsp_hash  <= core_out;
                        rsp_valid <= own_oh;
                        rr_ptr    <= grant_id;
                        wd_cnt    <= '0;
                        state     <= IDLE;
                        if (more_lat) proto_err <= 1'b1;
                    end else if (core_hash_next) begin
                        wd_cnt <= '0;
                        if (more_lat) state <= NEXT;
                        else          proto_err <= 1'b1;
                    end else if (wd_hit) begin
                        core_abort <= 1'b1;
                        rsp_valid  <= own_oh;
                        rsp_err    <= 1'b1;
                        rsp_hash   <= '0;
                        rr_ptr     <= grant_id;
                        wd_cnt     <= '0;
                        state      <= ABORT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (wd_hit) begin
                        core_abort <= 1'b1;
                        rsp_valid  <= own_oh;
                        rsp_err    <= 1'b1;
                        rsp_hash   <= '0;
                        rr_ptr     <= grant_id;
                        wd_cnt     <= '0;
                        state      <= ABORT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (issue) state <= BUSY;
                    end
                end
                // One quiet cycle while the core soft-clears before re-arbitrating.
                ABORT: begin
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
